// File: rtl/imc_pkg.sv
// Shared types and helpers for the IMC majority sequencer.
// Program entry layout, LSB first: src_a, src_b, src_c, dst (ADDR_W bits each), then inv[2:0].
package imc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        RD_C  = 3'd3,
        CAP_C = 3'd4,
        WR    = 3'd5,
        DONE  = 3'd6
    } state_e;

    // Field slot indices inside a program entry; bit offset = slot * ADDR_W.
    localparam int FLD_SRC_A = 0;
    localparam int FLD_SRC_B = 1;
    localparam int FLD_SRC_C = 2;
    localparam int FLD_DST   = 3;
    localparam int FLD_INV   = 4;

    // Single-bit three-input majority.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/imc_maj_prog_rf.sv
// Program store: DEPTH entries, one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; entries are undefined until written.
module imc_maj_prog_rf #(
    parameter  int DEPTH   = 8,
    parameter  int ENTRY_W = 23,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [PTR_W-1:0]   rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Write port: one entry per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/imc_maj_sequencer.sv
// IMC majority sequencer: runs up to DEPTH stored MAJ ops against the IMC array,
// five cycles per op (read A, read B, read C, capture C, write result).
// All memory-side outputs are registered; they are decoded from the next state.
// Optional feature macro: IMC_PERF_CNT_EN adds ops_done / run_cycles counters.
module imc_maj_sequencer
    import imc_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 5,
    parameter  int DEPTH   = 8,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int ENTRY_W = 4*ADDR_W + 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [PTR_W-1:0]   prog_addr,
    input  logic [ENTRY_W-1:0] prog_data,
    input  logic [PTR_W:0]     op_count,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_cs,
    output logic               mem_oe,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
`ifdef IMC_PERF_CNT_EN
    ,
    output logic [15:0]        ops_done,
    output logic [15:0]        run_cycles
`endif
);

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    pc_q, pc_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [DATA_W-1:0]   ra_q, ra_d;
    logic [DATA_W-1:0]   rb_q, rb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_cs_q, mem_cs_d;
    logic                mem_oe_q, mem_oe_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                prog_wr_en;
    logic [ENTRY_W-1:0]  rf_rdata;
    logic [ENTRY_W-1:0]  entry;
    logic [ADDR_W-1:0]   src_a, src_b, src_c, dst;
    logic [2:0]          inv;
    logic                last_op;

    // Program edits are only accepted while not running.
    assign prog_wr_en = prog_we && (state_q == IDLE || state_q == DONE);

    imc_maj_prog_rf #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_prog_rf (
        .clk     (clk),
        .we      (prog_wr_en),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (pc_d),
        .rd_data (rf_rdata)
    );

    // Bypass so an entry written in the same cycle as start is seen by op 0.
    assign entry = (prog_wr_en && prog_addr == pc_d) ? prog_data : rf_rdata;
    assign src_a = entry[FLD_SRC_A*ADDR_W +: ADDR_W];
    assign src_b = entry[FLD_SRC_B*ADDR_W +: ADDR_W];
    assign src_c = entry[FLD_SRC_C*ADDR_W +: ADDR_W];
    assign dst   = entry[FLD_DST*ADDR_W   +: ADDR_W];
    assign inv   = entry[FLD_INV*ADDR_W   +: 3];

    assign last_op = ({1'b0, pc_q} == (count_q - (PTR_W+1)'(1)));

    // 0 runs one op; anything above DEPTH runs DEPTH ops.
    function automatic logic [PTR_W:0] clamp_count(input logic [PTR_W:0] n);
        logic [PTR_W:0] r;
        r = n;
        if (n == '0) begin
            r = (PTR_W+1)'(1);
        end else if (n > (PTR_W+1)'(DEPTH)) begin
            r = (PTR_W+1)'(DEPTH);
        end
        return r;
    endfunction

    // Next-state, program counter and operand capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = clamp_count(op_count);
                    pc_d    = '0;
                    state_d = RD_A;
                end
            end
            RD_A:  state_d = RD_B;
            RD_B: begin
                ra_d    = mem_rdata;
                state_d = RD_C;
            end
            RD_C: begin
                rb_d    = mem_rdata;
                state_d = CAP_C;
            end
            // Row C is on mem_rdata now and is folded straight into wdata below.
            CAP_C: state_d = WR;
            WR: begin
                if (last_op) begin
                    state_d = DONE;
                end else begin
                    pc_d    = pc_q + PTR_W'(1);
                    state_d = RD_A;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered memory interface and status, decoded from the state being entered.
    always_comb begin
        mem_addr_d  = '0;
        mem_cs_d    = 1'b0;
        mem_oe_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wdata_d = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            RD_A: begin
                mem_addr_d = src_a;
                mem_cs_d   = 1'b1;
                mem_oe_d   = 1'b1;
                busy_d     = 1'b1;
            end
            RD_B: begin
                mem_addr_d = src_b;
                mem_cs_d   = 1'b1;
                mem_oe_d   = 1'b1;
                busy_d     = 1'b1;
            end
            RD_C: begin
                mem_addr_d = src_c;
                mem_cs_d   = 1'b1;
                mem_oe_d   = 1'b1;
                busy_d     = 1'b1;
            end
            CAP_C: busy_d = 1'b1;
            WR: begin
                mem_addr_d = dst;
                mem_cs_d   = 1'b1;
                mem_we_d   = 1'b1;
                busy_d     = 1'b1;
                for (int i = 0; i < DATA_W; i++) begin
                    mem_wdata_d[i] = maj3(ra_q[i] ^ inv[0], rb_q[i] ^ inv[1], mem_rdata[i] ^ inv[2]);
                end
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Control state and outputs reset; captured operand rows are not.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_cs_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_addr_q  <= mem_addr_d;
            mem_cs_q    <= mem_cs_d;
            mem_oe_q    <= mem_oe_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
        ra_q <= ra_d;
        rb_q <= rb_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_cs    = mem_cs_q;
    assign mem_oe    = mem_oe_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

`ifdef IMC_PERF_CNT_EN
    logic [15:0] ops_done_q, ops_done_d;
    logic [15:0] run_cycles_q, run_cycles_d;

    // Saturating counters: total ops since reset, and cycles of the latest run
    // (busy cycles plus the done cycle).
    always_comb begin
        ops_done_d   = ops_done_q;
        run_cycles_d = run_cycles_q;
        if (state_q == WR && ops_done_q != 16'hFFFF) begin
            ops_done_d = ops_done_q + 16'd1;
        end
        if (state_q == IDLE && start) begin
            run_cycles_d = '0;
        end else if ((busy_q || done_q) && run_cycles_q != 16'hFFFF) begin
            run_cycles_d = run_cycles_q + 16'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done_q   <= '0;
            run_cycles_q <= '0;
        end else begin
            ops_done_q   <= ops_done_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign ops_done   = ops_done_q;
    assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_imc_maj_sequencer.sv
// Directed bench for imc_maj_sequencer with a registered-read IMC row model.
module tb_imc_maj_sequencer;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 8;
    localparam int PTR_W   = 3;
    localparam int ENTRY_W = 4*ADDR_W + 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               prog_we;
    logic [PTR_W-1:0]   prog_addr;
    logic [ENTRY_W-1:0] prog_data;
    logic [PTR_W:0]     op_count;
    logic               start;
    logic               busy, done;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_cs, mem_oe, mem_we;
    logic [DATA_W-1:0]  mem_wdata, mem_rdata;
`ifdef IMC_PERF_CNT_EN
    logic [15:0]        ops_done, run_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int both_cnt = 0;

    imc_maj_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .op_count  (op_count),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_cs    (mem_cs),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef IMC_PERF_CNT_EN
        ,
        .ops_done  (ops_done),
        .run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    // IMC row model: read data valid the cycle after cs&oe; bench preload port.
    logic [DATA_W-1:0] row [32];
    logic              tb_wr_en = 1'b0;
    logic [ADDR_W-1:0] tb_wr_addr = '0;
    logic [DATA_W-1:0] tb_wr_data = '0;

    always @(posedge clk) begin
        if (tb_wr_en) row[tb_wr_addr] <= tb_wr_data;
        else if (mem_cs && mem_we) row[mem_addr] <= mem_wdata;
        if (mem_cs && mem_oe) mem_rdata <= row[mem_addr];
        if (mem_oe && mem_we) both_cnt <= both_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] mk_op(input logic [2:0] inv, input logic [4:0] d,
                                                   input logic [4:0] c, input logic [4:0] b,
                                                   input logic [4:0] a);
        return {inv, d, c, b, a};
    endfunction

    function automatic logic [31:0] gold(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [2:0] inv);
        logic [31:0] x, y, z;
        x = a ^ {32{inv[0]}};
        y = b ^ {32{inv[1]}};
        z = c ^ {32{inv[2]}};
        return (x & y) | (x & z) | (y & z);
    endfunction

    task automatic set_row(input logic [4:0] a, input logic [31:0] d);
        tb_wr_en = 1'b1; tb_wr_addr = a; tb_wr_data = d;
        @(negedge clk);
        tb_wr_en = 1'b0;
    endtask

    task automatic prog(input int idx, input logic [ENTRY_W-1:0] d);
        prog_we = 1'b1; prog_addr = PTR_W'(idx); prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Pulse start, measure cycles to done and busy cycles, then step once more
    // (back in IDLE) and report whether done is still high.
    task automatic run(input int cnt, output int lat, output int bc, output logic done_after);
        op_count = (PTR_W+1)'(cnt);
        start = 1'b1;
        lat = 0; bc = 0;
        do begin
            @(negedge clk);
            start = 1'b0; prog_we = 1'b0;
            lat++;
            if (busy) bc++;
        end while (!done && lat < 200);
        @(negedge clk);
        done_after = done;
    endtask

    localparam logic [31:0] RA = 32'h0000FFFF;
    localparam logic [31:0] RB = 32'h00FF00FF;
    localparam logic [31:0] RC = 32'h0F0F0F0F;

    initial begin
        int lat, bc, pulses, first, exp_ops;
        logic da;
        logic [31:0] g;
        logic [31:0] rc_k;
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        op_count = '0; start = 1'b0;
        exp_ops = 0;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy},   0);
        check("rst_done",  {31'd0, done},   0);
        check("rst_cs",    {31'd0, mem_cs}, 0);
        check("rst_oe",    {31'd0, mem_oe}, 0);
        check("rst_we",    {31'd0, mem_we}, 0);
        check("rst_addr",  {27'd0, mem_addr}, 0);
        check("rst_wdata", mem_wdata, 0);
        rst = 1'b0;

        set_row(1, RA); set_row(2, RB); set_row(3, RC);
        set_row(4, 32'h12345678); set_row(5, 32'hA5A5A5A5); set_row(6, 32'h0FF000FF);

        // Single op, no inversion
        prog(0, mk_op(3'b000, 7, 3, 2, 1));
        run(1, lat, bc, da);
        check("op1_latency", lat, 6);
        check("op1_busy",    bc, 5);
        check("op1_row7",    row[7], 32'h000F0FFF);
        check("op1_done_pulse", {31'd0, da}, 0);
        exp_ops += 1;

        // Invert A only: a becomes 0xFFFF0000
        prog(0, mk_op(3'b001, 7, 3, 2, 1));
        run(1, lat, bc, da);
        check("inv001_row7", row[7], 32'h0FFF000F);
        exp_ops += 1;

        // Invert all: complement of the plain majority
        prog(0, mk_op(3'b111, 7, 3, 2, 1));
        run(1, lat, bc, da);
        check("inv111_row7", row[7], 32'hFFF0F000);
        exp_ops += 1;

        // 4-op chain: op k writes row 10+k, feeding src_a of op k+1
        g = RA;
        for (int k = 0; k < 4; k++) begin
            rc_k = (k % 2 == 0) ? 32'hA5A5A5A5 : 32'h0FF000FF;
            prog(k, mk_op(3'(k), 5'(10 + k), (k % 2 == 0) ? 5'd5 : 5'd6, 5'd4,
                          (k == 0) ? 5'd1 : 5'(9 + k)));
            g = gold(g, 32'h12345678, rc_k, 3'(k));
        end
        run(4, lat, bc, da);
        check("chain_latency", lat, 21);
        check("chain_busy",    bc, 20);
        check("chain_row13",   row[13], g);
        check("chain_row10",   row[10], gold(RA, 32'h12345678, 32'hA5A5A5A5, 3'd0));
        exp_ops += 4;

        // start and prog_we while busy are ignored
        prog(0, mk_op(3'b000, 8, 3, 2, 1));
        set_row(8, 0); set_row(9, 0);
        op_count = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; prog_we = 1'b1; prog_addr = 0; prog_data = mk_op(3'b111, 9, 3, 2, 1);
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        pulses = 0; first = 0;
        for (int c = 4; c < 16; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first == 0) first = c;
            end
        end
        check("busy_done_pulses", pulses, 1);
        check("busy_latency",     first, 6);
        check("busy_row8",        row[8], 32'h000F0FFF);
        exp_ops += 1;
        set_row(8, 0);
        run(1, lat, bc, da);
        check("prog_kept_row8", row[8], 32'h000F0FFF);
        check("prog_kept_row9", row[9], 0);
        exp_ops += 1;

        // prog_we and start in the same IDLE cycle: op 0 uses the new entry
        prog(0, mk_op(3'b000, 20, 3, 2, 1));
        set_row(20, 0); set_row(21, 0);
        prog_we = 1'b1; prog_addr = 0; prog_data = mk_op(3'b111, 21, 3, 2, 1);
        run(1, lat, bc, da);
        check("same_cyc_row21", row[21], 32'hFFF0F000);
        check("same_cyc_row20", row[20], 0);
        exp_ops += 1;

        // Reset during RD_C of the third op (pc=2)
        prog(0, mk_op(3'b000, 10, 3, 2, 1));
        prog(1, mk_op(3'b000, 11, 3, 2, 1));
        prog(2, mk_op(3'b000, 12, 3, 2, 1));
        set_row(12, 0);
        op_count = 3; start = 1'b1;
        repeat (13) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("rdc_addr", {27'd0, mem_addr}, 3);
        check("rdc_oe",   {31'd0, mem_oe},   1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0;
        check("midrst_cs",   {31'd0, mem_cs}, 0);
        check("midrst_oe",   {31'd0, mem_oe}, 0);
        check("midrst_we",   {31'd0, mem_we}, 0);
        check("midrst_busy", {31'd0, busy},   0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("midrst_no_done", pulses, 0);
        check("midrst_row12",   row[12], 0);
        set_row(10, 0);
        run(1, lat, bc, da);
        check("after_rst_latency", lat, 6);
        check("after_rst_row10",   row[10], 32'h000F0FFF);
        exp_ops += 1;

        // op_count = 0 runs exactly one op
        run(0, lat, bc, da);
        check("cnt0_latency", lat, 6);
        check("cnt0_busy",    bc, 5);
        exp_ops += 1;

        // op_count = DEPTH+3 clamps to DEPTH ops
        for (int k = 0; k < DEPTH; k++) prog(k, mk_op(3'b000, 5'(14 + k), 3, 2, 1));
        set_row(21, 0);
        run(DEPTH + 3, lat, bc, da);
        check("clamp_latency", lat, 5*DEPTH + 1);
        check("clamp_busy",    bc, 5*DEPTH);
        check("clamp_row21",   row[21], 32'h000F0FFF);
        exp_ops += DEPTH;
`ifdef IMC_PERF_CNT_EN
        check("perf_run_cycles", {16'd0, run_cycles}, 5*DEPTH + 1);
        check("perf_ops_done",   {16'd0, ops_done},   exp_ops);
`endif

        check("oe_we_exclusive", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
